seg_execute_muldiv: RTL

//  Multi-cycle multiply/divide sequencer beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU,

---
 rtl/seg_execute_muldiv.sv | 106 ++++++++++
 1 files changed

// File: rtl/seg_execute_muldiv.sv
// seg_execute_muldiv: multi-cycle MULT/MULTU/DIV/DIVU sequencer writing HI/LO and stalling EX while busy.
// Optional MULDIV_FAST_MULT_EN: single-cycle multiplies, divide stays iterative.
module seg_execute_muldiv #(
  parameter int LEN = 32,
  parameter int NB_OP = 2,
  parameter int NB_CNT = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NB_OP-1:0] i_op,
  input  logic [LEN-1:0]   i_data_a,
  input  logic [LEN-1:0]   i_data_b,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [LEN-1:0]   o_hi,
  output logic [LEN-1:0]   o_lo
);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  state_t state;
  logic is_div, res_neg, rem_neg, sgn;
  logic [NB_CNT-1:0] cnt;
  logic [LEN-1:0] opb, abs_a, abs_b, quot, rem;
  logic [2*LEN-1:0] acc, step, prod;
  logic [LEN:0] mul_sum, rem_ext, diff;
  assign sgn = ~i_op[0];
  assign abs_a = (sgn & i_data_a[LEN-1]) ? -i_data_a : i_data_a;
  assign abs_b = (sgn & i_data_b[LEN-1]) ? -i_data_b : i_data_b;
  // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum = {1'b0, acc[2*LEN-1:LEN]} + {1'b0, opb};
  assign rem_ext = acc[2*LEN-1:LEN-1];
  assign diff = rem_ext - {1'b0, opb};
  assign step = is_div ? (diff[LEN] ? {rem_ext[LEN-1:0], acc[LEN-2:0], 1'b0}
                                    : {diff[LEN-1:0], acc[LEN-2:0], 1'b1})
                       : (acc[0] ? {mul_sum, acc[LEN-1:1]} : {1'b0, acc[2*LEN-1:1]});
  assign prod = res_neg ? -acc : acc;
  assign quot = res_neg ? -acc[LEN-1:0] : acc[LEN-1:0];
  assign rem = rem_neg ? -acc[2*LEN-1:LEN] : acc[2*LEN-1:LEN];
  assign o_stall = (state == IDLE && i_start) || state == RUN || state == SIGN;
  assign o_busy = state != IDLE;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*LEN-1:0] ext_a, ext_b, fast_prod;
  // sign-extended operands give the signed product modulo 2**(2*LEN)
  assign ext_a = {{LEN{sgn & i_data_a[LEN-1]}}, i_data_a};
  assign ext_b = {{LEN{sgn & i_data_b[LEN-1]}}, i_data_b};
  assign fast_prod = ext_a * ext_b;
`endif
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_hi <= '0;
      o_lo <= '0;
      o_done <= 1'b0;
      o_div_by_zero <= 1'b0;
      acc <= '0;
      opb <= '0;
      is_div <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_div_by_zero <= 1'b0;
      if (i_flush) state <= IDLE;
      else case (state)
        IDLE: if (i_start) begin
          is_div <= i_op[1];
          res_neg <= sgn & (i_data_a[LEN-1] ^ i_data_b[LEN-1]);
          rem_neg <= sgn & i_data_a[LEN-1];
          opb <= i_op[1] ? abs_b : abs_a;
          acc <= {{LEN{1'b0}}, i_op[1] ? abs_a : abs_b};
          cnt <= NB_CNT'(LEN - 1);
          if (i_op[1] && i_data_b == '0) begin
            state <= DONE;
            o_done <= 1'b1;
            o_div_by_zero <= 1'b1;
            o_hi <= i_data_a;
            o_lo <= '1;
          end
`ifdef MULDIV_FAST_MULT_EN
          else if (!i_op[1]) begin
            state <= DONE;
            o_done <= 1'b1;
            {o_hi, o_lo} <= fast_prod;
          end
`endif
          else state <= RUN;
        end
        RUN: begin
          acc <= step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= SIGN;
        end
        SIGN: begin
          state <= DONE;
          o_done <= 1'b1;
          {o_hi, o_lo} <= is_div ? {rem, quot} : prod;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
